// File: rtl/ars_pkg.sv
// Shared types for the field-multiplier arbiter: field width, element type, FSM states.
package ars_pkg;

    localparam int M_FIELD = 233;

    typedef logic [M_FIELD-1:0] fe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        REL  = 2'd2
    } ars_state_e;

endpackage

// File: rtl/ars_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module ars_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate requests so ptr lands on bit 0, take the lowest set bit, rotate the index back.
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IW'(i);
            end
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        idx_o = sum[IW-1:0];
        gnt_o = '0;
        if (|req_i) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/ars_mult_arbiter.sv
// Round-robin arbiter sharing one GF(2^m) multiplier among N requesters.
// States:
//   IDLE | waiting for a request; next grant chosen from ptr onward
//   BUSY | operands latched, mult_en high until mult_rdy or timeout
//   REL  | mult_en low for one cycle so the multiplier drops its ready
module ars_mult_arbiter
    import ars_pkg::*;
#(
    parameter int N   = 4,
    parameter int M   = M_FIELD,
    parameter int TMO = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic [N*M-1:0]         op_a,
    input  logic [N*M-1:0]         op_b,
    output logic [N-1:0]           done,
    output logic                   err,
    output logic [M-1:0]           res,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   gnt_id,
    output logic                   mult_en,
    output logic [M-1:0]           mult_a,
    output logic [M-1:0]           mult_b,
    input  logic                   mult_rdy,
    input  logic [M-1:0]           mult_z
);

    localparam int IW     = $clog2(N);
    localparam int TW     = (TMO > 1) ? $clog2(TMO) : 1;
    localparam int TLIM_I = (TMO > 0) ? TMO - 1 : 0;
    localparam logic [TW-1:0] TLIM = TW'(TLIM_I);

    ars_state_e     state_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  ptr_d;
    logic [IW-1:0]  gnt_q;
    logic [TW-1:0]  tcnt_q;
    logic [N-1:0]   done_q;
    logic [N-1:0]   done_d;
    logic           err_q;
    logic [M-1:0]   res_q;
    logic           busy_q;
    logic           en_q;
    logic [M-1:0]   a_q;
    logic [M-1:0]   b_q;

    logic [N-1:0]   pick_gnt;
    logic [IW-1:0]  pick_idx;
    logic           tmo_hit;

    ars_rr_pick #(.N(N)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // A timeout of zero never fires; rdy takes precedence when both land together.
    assign tmo_hit = (TMO != 0) && (tcnt_q == TLIM);

    // Next pointer and completion vector both follow the active grant.
    always_comb begin
        ptr_d = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
        done_d = '0;
        done_d[gnt_q] = 1'b1;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            tcnt_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pick_gnt) begin
                        a_q     <= op_a[pick_idx*M +: M];
                        b_q     <= op_b[pick_idx*M +: M];
                        gnt_q   <= pick_idx;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        tcnt_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (mult_rdy || tmo_hit) begin
                        if (mult_rdy) begin
                            res_q <= mult_z;
                        end else begin
                            err_q <= 1'b1;
                        end
                        done_q  <= done_d;
                        en_q    <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= REL;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                REL: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done    = done_q;
    assign err     = err_q;
    assign res     = res_q;
    assign busy    = busy_q;
    assign gnt_id  = gnt_q;
    assign mult_en = en_q;
    assign mult_a  = a_q;
    assign mult_b  = b_q;

endmodule

// File: tb/tb_ars_mult_arbiter.sv
// Bench for ars_mult_arbiter: timeline model of grants/completions plus directed scenarios.
module tb_ars_mult_arbiter;
    import ars_pkg::*;

    localparam int N   = 4;
    localparam int M   = M_FIELD;
    localparam int TMO = 16;
    localparam fe_t POLY = fe_t'(1) | (fe_t'(1) << 74);

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N*M-1:0]   op_a;
    logic [N*M-1:0]   op_b;
    logic [N-1:0]     done;
    logic             err;
    logic [M-1:0]     res;
    logic             busy;
    logic [1:0]       gnt_id;
    logic             mult_en;
    logic [M-1:0]     mult_a;
    logic [M-1:0]     mult_b;
    logic             mult_rdy;
    fe_t              mult_z;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  lat;
    bit  stray;
    fe_t junk;

    // model state
    bit  act = 1'b0;
    int  t_g, k_g, gid, ptr_m, last_gnt;
    bit  e_g;
    fe_t ga, gb, last_a, last_b, last_res;
    logic [N-1:0] e_done;
    logic e_err, e_en, e_busy;

    // completion log
    int  ev_cyc[$];
    int  ev_id[$];
    int  ev_gnt[$];
    bit  ev_err[$];
    fe_t ev_res[$];

    ars_mult_arbiter #(.N(N), .M(M), .TMO(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .done     (done),
        .err      (err),
        .res      (res),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .mult_en  (mult_en),
        .mult_a   (mult_a),
        .mult_b   (mult_b),
        .mult_rdy (mult_rdy),
        .mult_z   (mult_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic fe_t gf_mul(fe_t a, fe_t b);
        fe_t r;
        fe_t x;
        logic top;
        r = '0;
        x = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r ^= x;
            top = x[M-1];
            x = x << 1;
            if (top) x ^= POLY;
        end
        return r;
    endfunction

    task automatic chk(string name, logic [255:0] act_v, logic [255:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act_v, exp_v);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(int i, fe_t a, fe_t b);
        op_a[i*M +: M] = a;
        op_b[i*M +: M] = b;
    endtask

    task automatic wait_done(int target, int budget);
        int n;
        n = 0;
        while (ev_id.size() < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (ev_id.size() < target) begin
            checks++;
            errors++;
            $display("FAIL wait_done: actual=%0d completions required=%0d", ev_id.size(), target);
        end
    endtask

    // Multiplier model: rdy on the lat-th cycle of mult_en (lat=0: never), optional stray rdy while idle.
    initial begin
        int cnt;
        cnt = 0;
        mult_rdy = 1'b0;
        mult_z = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mult_en) begin
                cnt = 0;
                mult_rdy = stray;
                mult_z = junk;
            end else begin
                cnt++;
                mult_rdy = (lat != 0) && (cnt == lat);
                mult_z = mult_rdy ? gf_mul(mult_a, mult_b) : junk;
            end
        end
    end

    // Timeline model and per-cycle comparison, one evaluation per cycle at the falling edge.
    always @(negedge clk) begin
        bit found;
        int w;
        cyc++;
        e_done = '0;
        e_err  = 1'b0;
        e_en   = 1'b0;
        e_busy = 1'b0;
        if (!rst_n) begin
            act = 1'b0;
            ptr_m = 0;
            last_gnt = 0;
            last_a = '0;
            last_b = '0;
            last_res = '0;
        end else if (act) begin
            if (cyc == t_g + k_g + 1) begin
                e_done[gid] = 1'b1;
                e_err = e_g;
                if (!e_g) last_res = gf_mul(ga, gb);
                ptr_m = (gid + 1) % N;
            end
            e_en   = (cyc >= t_g + 1) && (cyc <= t_g + k_g);
            e_busy = (cyc >= t_g + 1) && (cyc <= t_g + k_g + 1);
        end
        chk("done",    256'(done),    256'(e_done));
        chk("err",     256'(err),     256'(e_err));
        chk("res",     256'(res),     256'(last_res));
        chk("busy",    256'(busy),    256'(e_busy));
        chk("gnt_id",  256'(gnt_id),  256'(last_gnt));
        chk("mult_en", 256'(mult_en), 256'(e_en));
        chk("mult_a",  256'(mult_a),  256'(last_a));
        chk("mult_b",  256'(mult_b),  256'(last_b));
        if (done != '0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (done[i]) w = i;
            ev_cyc.push_back(cyc);
            ev_id.push_back(w);
            ev_gnt.push_back(int'(gnt_id));
            ev_err.push_back(err);
            ev_res.push_back(res);
        end
        if (rst_n && req != '0 && (!act || cyc >= t_g + k_g + 2)) begin
            found = 1'b0;
            w = 0;
            for (int j = 0; j < N; j++) begin
                if (!found && req[(ptr_m + j) % N]) begin
                    found = 1'b1;
                    w = (ptr_m + j) % N;
                end
            end
            gid = w;
            t_g = cyc;
            if (lat != 0 && lat <= TMO) begin
                k_g = lat;
                e_g = 1'b0;
            end else begin
                k_g = TMO;
                e_g = 1'b1;
            end
            ga = op_a[gid*M +: M];
            gb = op_b[gid*M +: M];
            last_a = ga;
            last_b = gb;
            last_gnt = gid;
            act = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;
        int nb;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req   = '0;
        op_a  = '0;
        op_b  = '0;
        lat   = 5;
        stray = 1'b0;
        junk  = '1;
        step(2);
        chk("rst_mult_en", 256'(mult_en), 256'(0));
        chk("rst_busy",    256'(busy),    256'(0));
        chk("rst_gnt_id",  256'(gnt_id),  256'(0));
        chk("rst_res",     256'(res),     256'(0));
        chk("rst_done",    256'(done),    256'(0));
        rst_n = 1'b1;
        step(2);

        // all requesters pending
        for (int i = 0; i < N; i++) set_op(i, fe_t'(i + 3), fe_t'(1) << (i + 100));
        req = '1;
        rc = cyc + 1;
        wait_done(5, 60);
        req = '0;
        if (ev_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("rr_order",  256'(ev_id[k]),  256'(exp_order[k]));
                chk("rr_gnt_id", 256'(ev_gnt[k]), 256'(exp_order[k]));
            end
            chk("rr_first_done", 256'(ev_cyc[0] - rc), 256'(6));
            for (int k = 1; k < 5; k++) chk("rr_spacing", 256'(ev_cyc[k] - ev_cyc[k-1]), 256'(7));
        end

        // single request
        step(2);
        set_op(1, fe_t'(1), fe_t'(1) << 232);
        req = 4'b0010;
        step(1);
        req = '0;
        wait_done(6, 20);
        step(10);
        chk("single_count", 256'(ev_id.size()), 256'(6));
        if (ev_id.size() >= 6) begin
            chk("single_id",  256'(ev_id[5]),  256'(1));
            chk("single_res", 256'(ev_res[5]), 256'(fe_t'(1) << 232));
        end

        // operand change and req drop after grant, stray rdy while not busy
        step(2);
        stray = 1'b1;
        set_op(2, fe_t'(8), fe_t'(32));
        req = 4'b0100;
        step(1);
        op_a[2*M +: M] = fe_t'(7);
        req = '0;
        step(2);
        chk("latched_mult_a", 256'(mult_a), 256'(8));
        wait_done(7, 20);
        stray = 1'b0;
        if (ev_id.size() >= 7) begin
            chk("latched_id",  256'(ev_id[6]),  256'(2));
            chk("latched_res", 256'(ev_res[6]), 256'(256));
        end

        // timeout, then pointer wrap to requester 0
        step(2);
        lat = 0;
        set_op(3, fe_t'(5), fe_t'(9));
        req = 4'b1000;
        rc = cyc + 1;
        step(1);
        req = '0;
        wait_done(8, 40);
        if (ev_id.size() >= 8) begin
            chk("tmo_err",   256'(ev_err[7]),       256'(1));
            chk("tmo_id",    256'(ev_id[7]),        256'(3));
            chk("tmo_res",   256'(ev_res[7]),       256'(256));
            chk("tmo_delay", 256'(ev_cyc[7] - rc),  256'(17));
        end
        step(2);
        lat = 5;
        set_op(0, fe_t'(3), fe_t'(3));
        set_op(1, fe_t'(4), fe_t'(4));
        req = 4'b0011;
        step(1);
        req = '0;
        wait_done(9, 20);
        if (ev_id.size() >= 9) begin
            chk("wrap_id",  256'(ev_id[8]),  256'(0));
            chk("wrap_err", 256'(ev_err[8]), 256'(0));
            chk("wrap_res", 256'(ev_res[8]), 256'(5));
        end

        // reset during BUSY
        step(2);
        set_op(2, fe_t'(6), fe_t'(6));
        req = 4'b0100;
        step(3);
        nb = ev_id.size();
        rst_n = 1'b0;
        #1;
        chk("rst_async_en",   256'(mult_en), 256'(0));
        chk("rst_async_busy", 256'(busy),    256'(0));
        req = 4'b0110;
        set_op(1, fe_t'(2), fe_t'(2));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        req = '0;
        wait_done(nb + 1, 20);
        if (ev_id.size() >= nb + 1) begin
            chk("rst_first_grant", 256'(ev_id[nb]),  256'(1));
            chk("rst_first_res",   256'(ev_res[nb]), 256'(4));
        end

        // rdy on the same cycle as the timeout
        step(2);
        lat = 16;
        set_op(0, fe_t'(1) << 232, fe_t'(2));
        req = 4'b0001;
        rc = cyc + 1;
        nb = ev_id.size();
        step(1);
        req = '0;
        wait_done(nb + 1, 40);
        if (ev_id.size() >= nb + 1) begin
            chk("tie_err",   256'(ev_err[nb]),      256'(0));
            chk("tie_id",    256'(ev_id[nb]),       256'(0));
            chk("tie_res",   256'(ev_res[nb]),      256'(POLY));
            chk("tie_delay", 256'(ev_cyc[nb] - rc), 256'(17));
        end

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
